input_port_buffer: RTL
======================

INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, flit width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, flit slots (power of two, >= 2).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port data_i  input  WIDTH  flit from the upstream link.
REQ-006 The block SHALL have port valid_i  input  1  data_i carries a flit this cycle.
REQ-007 The block SHALL have port data_o  output  WIDTH  head flit, driven to the inner router's per-port data input.
REQ-008 The block SHALL have port valid_o  output  1  head flit present, driven to the inner router's per-port valid input.
REQ-009 The block SHALL have port pop_i  input  1  inner router consumes the head flit this cycle.
REQ-010 The block SHALL have port credit_o  output  1  one-cycle pulse returning one buffer credit upstream.
REQ-011 The block SHALL have port count_o  output  $clog2(DEPTH+1)  current occupancy.
REQ-012 The block SHALL have port overflow_o  output  1  sticky error: a flit arrived while full and was dropped.

Function
REQ-013 The block SHALL be a circular FIFO with read/write pointers wrapping modulo DEPTH and an occupancy counter 0..DEPTH.
REQ-014 The block SHALL accept a push when valid_i=1 and (count_o<DEPTH or an accepted pop occurs in the same cycle).
REQ-015 The block SHALL accept a pop when pop_i=1 and valid_o=1; pop_i while empty SHALL be ignored with no state change and no credit.
REQ-016 valid_o SHALL equal (count_o != 0), combinationally from registered state.
REQ-017 data_o SHALL present the head slot when valid_o=1 and SHALL be all zeros when valid_o=0.
REQ-018 A pushed flit SHALL appear on data_o/valid_o no earlier than the cycle after the push (no same-cycle bypass).
REQ-019 Simultaneous accepted push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-020 count_o SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-021 valid_i=1 with count_o=DEPTH and no accepted pop SHALL drop the flit, leave pointers and count unchanged, and set overflow_o from the next cycle.
REQ-022 overflow_o SHALL remain 1 until reset.
REQ-023 credit_o SHALL be registered: 1 in the cycle after each accepted pop, else 0; back-to-back pops SHALL give back-to-back pulses.
REQ-024 Flits SHALL be delivered in arrival order with no duplication or loss other than REQ-021 drops.
REQ-025 Pointer wrap from DEPTH-1 to 0 SHALL be seamless across push, pop and simultaneous push/pop.

Reset
REQ-026 With reset=1 at a rising edge the block SHALL set pointers=0, count_o=0, valid_o=0, data_o=0, credit_o=0, overflow_o=0.
REQ-027 Reset SHALL take priority over simultaneous valid_i/pop_i in that cycle; buffered flits SHALL be discarded and no credit issued for them.
REQ-028 Storage array contents need not be reset.

Verification
REQ-029 Push 16'hA001..16'hA004 on 4 consecutive cycles, no pop -> count_o=4, valid_o=1, data_o=16'hA001, credit_o stays 0.
REQ-030 From full, pop on 4 consecutive cycles -> data_o A001,A002,A003,A004 in order; credit_o=1 on each of the 4 following cycles; then valid_o=0, data_o=0.
REQ-031 From full, push 16'hBEEF with no pop -> flit dropped, count_o stays 4, overflow_o=1 next cycle and stays 1; with pop_i=1 in the same cycle instead -> accepted, count_o stays 4, overflow_o stays 0.
REQ-032 Continuous push+pop for 10 cycles from count 2 -> pointers wrap at least twice, count_o constant 2, output order equals input order, 10 credit pulses.
REQ-033 pop_i=1 while empty -> no credit_o, count_o stays 0.
REQ-034 Reset asserted with 3 flits buffered and valid_i=pop_i=1 -> next cycle count_o=0, valid_o=0, overflow_o=0, credit_o=0.

Source files
------------

// File: rtl/input_port_buffer.sv
// Input-port flit buffer: circular FIFO between an upstream link and the inner router.
// Returns one credit per consumed flit and flags flits dropped on arrival while full.
module input_port_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         valid_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         valid_o,
    input  logic                         pop_i,
    output logic                         credit_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_credit;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [AW-1:0]    w_wr_ptr_nxt;
    logic [AW-1:0]    w_rd_ptr_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // A pop frees a slot in the same cycle, so a full buffer still accepts a push alongside a pop.
    assign w_pop  = pop_i & ~w_empty;
    assign w_push = valid_i & (~w_full | w_pop);
    assign w_drop = valid_i & w_full & ~w_pop;

    assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_credit <= w_pop;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is not cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    assign valid_o    = ~w_empty;
    assign data_o     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign count_o    = r_count;
    assign credit_o   = r_credit;
    assign overflow_o = r_overflow;

endmodule
